divider: RTL and testbench

//  Programmable integer clock divider. Produces clock_out at f(clk)/N, where N is

---
 rtl/divider_pkg.sv | 21 ++
 rtl/divider_clk_mux.sv | 24 ++
 rtl/divider.sv | 93 +++++++++
 tb/tb_divider.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: default counter width, special ratio codes, output-select
// encoding and the half-ratio helper shared by the divider files.
package divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam int DIV_OFF    = 0;
    localparam int DIV_BYPASS = 1;

    typedef enum logic [1:0] {
        SEL_OFF     = 2'd0,
        SEL_CLK     = 2'd1,
        SEL_POS     = 2'd2,
        SEL_POS_NEG = 2'd3
    } clk_sel_e;

    function automatic int unsigned half(input int unsigned n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/divider_clk_mux.sv
// divider_clk_mux: final clock_out source select (off / clk / pos_q / pos_q|neg_q).
// Kept in its own module so a library glitch-free clock-mux cell can replace it.
module divider_clk_mux (
    input  logic       clk,
    input  logic       pos_q,
    input  logic       neg_q,
    input  logic [1:0] sel,
    output logic       clock_out
);
    import divider_pkg::*;

    // Route the selected source to the output
    always_comb begin
        clock_out = 1'b0;
        case (clk_sel_e'(sel))
            SEL_OFF:     clock_out = 1'b0;
            SEL_CLK:     clock_out = clk;
            SEL_POS:     clock_out = pos_q;
            SEL_POS_NEG: clock_out = pos_q | neg_q;
            default:     clock_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/divider.sv
// divider: programmable integer clock divider, clock_out = f(clk)/N.
// A new ratio is adopted only at an output-period boundary.
// Optional macro DIVIDER_ODD_DUTY50_EN adds a negedge flop giving exact 50%
// duty for odd ratios; without it the design is posedge-only.
module divider #(
    parameter int WIDTH = divider_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] divide_in,
    output logic             clock_out
);
    import divider_pkg::*;

    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO    = WIDTH'(2);
    localparam logic [WIDTH-1:0] OFF    = WIDTH'(DIV_OFF);
    localparam logic [WIDTH-1:0] BYPASS = WIDTH'(DIV_BYPASS);

    logic [WIDTH-1:0] ratio_q;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ratio_next;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] ratio_half;
    logic             boundary;
    logic             pos_next;
    logic             pos_q;
    logic             neg_q;
    clk_sel_e         sel;

    // Period boundary detection and next-state for counter, ratio and output flop
    always_comb begin
        boundary   = (ratio_q < TWO) || (cnt == ratio_q - ONE);
        cnt_next   = cnt + ONE;
        ratio_next = ratio_q;
        if (boundary) begin
            cnt_next   = '0;
            ratio_next = divide_in;
        end
        ratio_half = WIDTH'(half(32'(ratio_next)));
        pos_next   = (cnt_next < ratio_half);
    end

    // Counter, ratio latch and posedge output flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ratio_q <= '0;
            cnt     <= '0;
            pos_q   <= 1'b0;
        end else begin
            ratio_q <= ratio_next;
            cnt     <= cnt_next;
            pos_q   <= pos_next;
        end
    end

`ifdef DIVIDER_ODD_DUTY50_EN
    // Half-cycle delayed copy of pos_q that stretches odd-ratio high time by half a clk
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end
`else
    assign neg_q = 1'b0;
`endif

    // Output source selection from the latched ratio
    always_comb begin
        sel = SEL_POS;
        if (ratio_q == OFF) begin
            sel = SEL_OFF;
        end else if (ratio_q == BYPASS) begin
            sel = SEL_CLK;
        end
`ifdef DIVIDER_ODD_DUTY50_EN
        else if (ratio_q[0]) begin
            sel = SEL_POS_NEG;
        end
`endif
    end

    divider_clk_mux u_clk_mux (
        .clk       (clk),
        .pos_q     (pos_q),
        .neg_q     (neg_q),
        .sel       (sel),
        .clock_out (clock_out)
    );

endmodule

// File: tb/tb_divider.sv
// tb_divider: randomized and directed checks of divider against a period/phase
// reference model. Build with DIVIDER_ODD_DUTY50_EN to check the 50% odd-duty variant.
`timescale 1ns/100ps
module tb_divider;

    localparam int WIDTH = 8;
`ifdef DIVIDER_ODD_DUTY50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] divide_in = WIDTH'(5);
    logic             clock_out;

    int checks = 0;
    int errors = 0;

    // Reference model: current ratio, posedge index where its period began, posedge count
    int m_ratio = 0;
    int m_start = 0;
    int m_cycle = 0;

    divider #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .divide_in (divide_in),
        .clock_out (clock_out)
    );

    always #1 clk = ~clk;

    function automatic int period_len(input int n);
        return (n < 2) ? 1 : n;
    endfunction

    // Expected output level: high for the first h half-cycles of each period
    function automatic logic expected_level(input int n, input int phase, input bit clk_high);
        int high_halves;
        int idx;
        if (rst) return 1'b0;
        if (n == 0) return 1'b0;
        if (n == 1) return clk_high;
        high_halves = (ODD50 && (n % 2 == 1)) ? n : (n / 2) * 2;
        idx = 2 * phase + (clk_high ? 0 : 1);
        return (idx < high_halves);
    endfunction

    // Advance the model at every posedge; a new ratio is taken once a full period has elapsed
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ratio = 0;
            m_start = m_cycle;
        end else begin
            m_cycle = m_cycle + 1;
            if (m_cycle - m_start >= period_len(m_ratio)) begin
                m_start = m_cycle;
                m_ratio = int'(divide_in);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (ratio %0d phase %0d) at %0t",
                     tag, actual, expected, m_ratio, m_cycle - m_start, $time);
        end
    endtask

    task automatic checkWave(input bit clk_high);
        checkOutput(clk_high ? "wave_hi" : "wave_lo", {31'd0, clock_out},
                    {31'd0, expected_level(m_ratio, m_cycle - m_start, clk_high)});
    endtask

    // Called at negedge+0.5; leaves the bench at negedge+0.5
    task automatic applyStimulus(input int n, input int cycles);
        divide_in = WIDTH'(n);
        repeat (cycles) begin
            @(posedge clk); #0.5; checkWave(1'b1);
            @(negedge clk); #0.5; checkWave(1'b0);
        end
    endtask

    // Assert reset between edges once the model reaches the given phase, then release
    task automatic resetAtPhase(input int target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #0.5; checkWave(1'b1);
            if (m_cycle - m_start == target) begin
                found = 1'b1;
            end else begin
                @(negedge clk); #0.5; checkWave(1'b0);
            end
        end
        checkOutput("phase_wait", {31'd0, found}, 32'd1);
        if (found) begin
            #0.2 rst = 1'b1;
            #0.2 checkOutput("async_drop", {31'd0, clock_out}, 32'd0);
            @(negedge clk); #0.5; checkWave(1'b0);
            @(posedge clk); #0.5; checkWave(1'b1);
            @(negedge clk); #0.5; checkWave(1'b0);
            checkOutput("rst_cnt_mid", 32'(dut.cnt), 32'd0);
            rst = 1'b0;
        end
    endtask

    initial begin
        #150000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        rst       = 1'b1;
        divide_in = WIDTH'(5);

        repeat (4) begin
            @(negedge clk); #0.5;
            checkOutput("rst_out", {31'd0, clock_out}, 32'd0);
            checkOutput("rst_cnt", 32'(dut.cnt), 32'd0);
            @(posedge clk); #0.5;
            checkOutput("rst_out", {31'd0, clock_out}, 32'd0);
        end
        @(negedge clk); #0.5;
        rst = 1'b0;
        @(posedge clk); #0.5;
        checkOutput("first_rise", {31'd0, clock_out}, 32'd1);
        checkWave(1'b1);
        @(negedge clk); #0.5; checkWave(1'b0);

        applyStimulus(4, 20);
        applyStimulus(2, 20);
        applyStimulus(3, 24);
        applyStimulus(7, 28);
        applyStimulus(0, 25);
        applyStimulus(1, 25);

        for (int v = 0; v <= 7; v++) applyStimulus(v, 25);
        for (int v = 6; v >= 1; v--) applyStimulus(v, 25);

        applyStimulus(6, 14);
        resetAtPhase(3);
        applyStimulus(6, 14);
        resetAtPhase(1);
        applyStimulus(6, 14);

        divide_in = WIDTH'(255);
        applyStimulus(255, 300);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) == 0) n = int'($urandom_range(0, 255));
            else                           n = int'($urandom_range(0, 12));
            applyStimulus(n, int'($urandom_range(1, 40)));
            if ($urandom_range(0, 19) == 0) resetAtPhase(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
